// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: stage indices,
// hold FSM states and the core-wide reset/stall level constants.
package pipe_ctrl_pkg;

  // Stage positions in the stall/flush vectors.
  localparam int STAGE_PC  = 0;
  localparam int STAGE_IF  = 1;
  localparam int STAGE_ID  = 2;
  localparam int STAGE_EX  = 3;
  localparam int STAGE_MEM = 4;
  localparam int STAGE_WB  = 5;

  // Core-wide level constants: reset is active-high, a set stall bit freezes.
  localparam logic RstEnable = 1'b1;
  localparam logic Stop      = 1'b1;

  // Multi-cycle hold FSM.
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } hold_state_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Request/response bundle between the pipeline stages and pipe_ctrl.
// The master side (pipeline) raises requests; the slave side (controller)
// returns the stall/flush vectors and performance counters.
interface pipe_ctrl_if #(
  parameter int STAGES = 6,
  parameter int HOLD_W = 4,
  parameter int PERF_W = 16
);
  import pipe_ctrl_pkg::*;

  localparam int SW = (STAGES > 1) ? $clog2(STAGES) : 1;

  logic [STAGES-1:0] stallreq;
  logic              hold_req;
  logic [SW-1:0]     hold_stage;
  logic [HOLD_W-1:0] hold_cycles;
  logic [STAGES-1:0] flushreq;
  logic              perf_clr;

  logic [STAGES-1:0] stall;
  logic [STAGES-1:0] flush;
  logic              hold_busy;
  logic [PERF_W-1:0] stall_cycles;
  logic [PERF_W-1:0] flush_events;

  modport master (
    output stallreq, hold_req, hold_stage, hold_cycles, flushreq, perf_clr,
    input  stall, flush, hold_busy, stall_cycles, flush_events
  );

  modport slave (
    input  stallreq, hold_req, hold_stage, hold_cycles, flushreq, perf_clr,
    output stall, flush, hold_busy, stall_cycles, flush_events
  );

endinterface

// File: rtl/pipe_ctrl_prio.sv
// Highest-set-bit encoder: returns the index of the most significant set
// request bit plus a flag telling whether any bit was set at all.
module pipe_ctrl_prio #(
  parameter int W  = 6,
  parameter int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  req_i,
  output logic [IW-1:0] idx_o,
  output logic          vld_o
);

  // Scan upward so the last (highest) set bit wins.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned, which would infer a latch.
    idx_o = '0;
    vld_o = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (req_i[i]) begin
        idx_o = IW'(i);
        vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: merges stall, multi-cycle hold and redirect
// requests into one stall vector and one bubble/flush vector, and keeps
// saturating stall/flush event counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int STAGES = 6,
  parameter int HOLD_W = 4,
  parameter int PERF_W = 16
) (
  input logic       clk,
  input logic       rst,
  pipe_ctrl_if.slave bus
);

  localparam int SW = (STAGES > 1) ? $clog2(STAGES) : 1;

  hold_state_e       state_q;
  logic [HOLD_W-1:0] cnt_q;
  logic [SW-1:0]     hold_stage_q;
  logic [PERF_W-1:0] stall_cycles_q;
  logic [PERF_W-1:0] flush_events_q;

  logic              hold_cand;
  logic              hold_act;
  logic              hold_accept;
  logic [SW-1:0]     hold_idx;
  logic [STAGES-1:0] stall_src;
  logic [STAGES-1:0] flush_src;
  logic [SW-1:0]     s_idx;
  logic              s_vld;
  logic [SW-1:0]     f_idx;
  logic              f_vld;
  logic              flush_win;
  logic [STAGES-1:0] stall_vec;
  logic [STAGES-1:0] flush_vec;

  // A new hold already stalls in its accept cycle, so the candidate stage is
  // folded into the stall request before the flush-vs-stall decision. If a
  // flush from above wins, the candidate is refused in the same cycle.
  assign hold_cand   = (state_q == IDLE) && bus.hold_req && (bus.hold_cycles != '0);
  assign hold_act    = (state_q == HOLD) || hold_cand;
  assign hold_idx    = (state_q == HOLD) ? hold_stage_q : bus.hold_stage;
  assign stall_src   = bus.stallreq | (hold_act ? (STAGES'(1) << hold_idx) : '0);
  assign flush_src   = {bus.flushreq[STAGES-1:1], 1'b0};
  assign flush_win   = f_vld && (!s_vld || (f_idx > s_idx));
  assign hold_accept = hold_cand && !flush_win;

  pipe_ctrl_prio #(.W(STAGES), .IW(SW)) u_stall_prio (
    .req_i (stall_src),
    .idx_o (s_idx),
    .vld_o (s_vld)
  );

  pipe_ctrl_prio #(.W(STAGES), .IW(SW)) u_flush_prio (
    .req_i (flush_src),
    .idx_o (f_idx),
    .vld_o (f_vld)
  );

  // Build stall/flush vectors: a winning flush squashes everything up to f,
  // otherwise freeze up to s and push a bubble into the stage just above.
  always_comb begin
    stall_vec = '0;
    flush_vec = '0;
    if (rst != RstEnable) begin
      if (flush_win) begin
        for (int j = 1; j < STAGES; j++) begin
          if (j <= int'(f_idx)) flush_vec[j] = 1'b1;
        end
      end else if (s_vld) begin
        for (int j = 0; j < STAGES; j++) begin
          if (j <= int'(s_idx))    stall_vec[j] = Stop;
          if (j == int'(s_idx) + 1) flush_vec[j] = 1'b1;
        end
      end
    end
  end

  // Hold FSM, hold counter and saturating performance counters.
  // cnt_q holds the number of HOLD cycles still to spend, current included.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values, independent of statement order.
    if (rst == RstEnable) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      hold_stage_q   <= '0;
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hold_accept) begin
            hold_stage_q <= bus.hold_stage;
            if (bus.hold_cycles == HOLD_W'(1)) begin
              cnt_q <= '0;
            end else begin
              state_q <= HOLD;
              cnt_q   <= bus.hold_cycles - HOLD_W'(1);
            end
          end
        end
        HOLD: begin
          if (flush_win || (cnt_q <= HOLD_W'(1))) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - HOLD_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase

      if (bus.perf_clr) begin
        stall_cycles_q <= '0;
        flush_events_q <= '0;
      end else begin
        if (stall_vec[0] && !(&stall_cycles_q)) stall_cycles_q <= stall_cycles_q + PERF_W'(1);
        if (flush_win && !(&flush_events_q))    flush_events_q <= flush_events_q + PERF_W'(1);
      end
    end
  end

  assign bus.stall        = stall_vec;
  assign bus.flush        = flush_vec;
  assign bus.hold_busy    = (state_q == HOLD);
  assign bus.stall_cycles = stall_cycles_q;
  assign bus.flush_events = flush_events_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: each stimulus cycle pushes its
// hand-computed expectation; a monitor pops and compares at the falling edge.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int STAGES = 6;
  localparam int HOLD_W = 4;
  localparam int PERF_W = 4;

  typedef struct {
    string      name;
    logic [5:0] stall;
    logic [5:0] flush;
    logic       busy;
    logic [3:0] sc;
    logic [3:0] fe;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  pipe_ctrl_if #(.STAGES(STAGES), .HOLD_W(HOLD_W), .PERF_W(PERF_W)) bus ();

  pipe_ctrl #(.STAGES(STAGES), .HOLD_W(HOLD_W), .PERF_W(PERF_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge and queue its expectation.
  task automatic step(input string name, input logic r,
                      input logic [5:0] sreq, input logic [5:0] freq,
                      input logic hreq, input logic [2:0] hst, input logic [3:0] hcyc,
                      input logic pclr,
                      input logic [5:0] est, input logic [5:0] efl, input logic ebusy,
                      input logic [3:0] esc, input logic [3:0] efe);
    exp_t e;
    @(posedge clk);
    #1;
    rst             = r;
    bus.stallreq    = sreq;
    bus.flushreq    = freq;
    bus.hold_req    = hreq;
    bus.hold_stage  = hst;
    bus.hold_cycles = hcyc;
    bus.perf_clr    = pclr;
    e.name  = name;
    e.stall = est;
    e.flush = efl;
    e.busy  = ebusy;
    e.sc    = esc;
    e.fe    = efe;
    exp_q.push_back(e);
  endtask

  // Monitor: compare the DUT against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.name, " stall"},        32'(bus.stall),        32'(e.stall));
        check({e.name, " flush"},        32'(bus.flush),        32'(e.flush));
        check({e.name, " hold_busy"},    32'(bus.hold_busy),    32'(e.busy));
        check({e.name, " stall_cycles"}, 32'(bus.stall_cycles), 32'(e.sc));
        check({e.name, " flush_events"}, 32'(bus.flush_events), 32'(e.fe));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.stallreq    = '0;
    bus.flushreq    = '0;
    bus.hold_req    = 1'b0;
    bus.hold_stage  = '0;
    bus.hold_cycles = '0;
    bus.perf_clr    = 1'b0;

    //    name          rst sreq       freq       hr hst   hcyc  clr est        efl        busy sc     fe
    step("reset",       1, 6'b000000, 6'b000000, 0, 3'd0, 4'd0, 0, 6'b000000, 6'b000000, 0, 4'd0, 4'd0);
    step("idle",        0, 6'b000000, 6'b000000, 0, 3'd0, 4'd0, 0, 6'b000000, 6'b000000, 0, 4'd0, 4'd0);
    // Load-use stall at ID.
    step("lu1",         0, 6'b000100, 6'b000000, 0, 3'd0, 4'd0, 0, 6'b000111, 6'b001000, 0, 4'd0, 4'd0);
    step("lu2",         0, 6'b000100, 6'b000000, 0, 3'd0, 4'd0, 0, 6'b000111, 6'b001000, 0, 4'd1, 4'd0);
    step("lu3",         0, 6'b000100, 6'b000000, 0, 3'd0, 4'd0, 0, 6'b000111, 6'b001000, 0, 4'd2, 4'd0);
    step("lu_end",      0, 6'b000000, 6'b000000, 0, 3'd0, 4'd0, 0, 6'b000000, 6'b000000, 0, 4'd3, 4'd0);
    // Branch from EX beats ID stall.
    step("br",          0, 6'b000100, 6'b001000, 0, 3'd0, 4'd0, 0, 6'b000000, 6'b001110, 0, 4'd3, 4'd0);
    step("br_end",      0, 6'b000000, 6'b000000, 0, 3'd0, 4'd0, 0, 6'b000000, 6'b000000, 0, 4'd3, 4'd1);
    // MEM stall outranks EX flush.
    step("outrank",     0, 6'b010000, 6'b001000, 0, 3'd0, 4'd0, 0, 6'b011111, 6'b100000, 0, 4'd3, 4'd1);
    step("outrank_end", 0, 6'b000000, 6'b000000, 0, 3'd0, 4'd0, 0, 6'b000000, 6'b000000, 0, 4'd4, 4'd1);
    // flushreq[0] is ignored.
    step("flush0",      0, 6'b000000, 6'b000001, 0, 3'd0, 4'd0, 0, 6'b000000, 6'b000000, 0, 4'd4, 4'd1);
    step("flush0_end",  0, 6'b000000, 6'b000000, 0, 3'd0, 4'd0, 0, 6'b000000, 6'b000000, 0, 4'd4, 4'd1);
    // Top stage boundaries.
    step("flush_wb",    0, 6'b000000, 6'b100000, 0, 3'd0, 4'd0, 0, 6'b000000, 6'b111110, 0, 4'd4, 4'd1);
    step("stall_wb",    0, 6'b100000, 6'b000000, 0, 3'd0, 4'd0, 0, 6'b111111, 6'b000000, 0, 4'd4, 4'd2);
    step("stall_wb_end",0, 6'b000000, 6'b000000, 0, 3'd0, 4'd0, 0, 6'b000000, 6'b000000, 0, 4'd5, 4'd2);
    // Hold at EX for 4 cycles; second request during HOLD ignored.
    step("hold1",       0, 6'b000000, 6'b000000, 1, 3'd3, 4'd4, 0, 6'b001111, 6'b010000, 0, 4'd5, 4'd2);
    step("hold2",       0, 6'b000000, 6'b000000, 1, 3'd1, 4'd9, 0, 6'b001111, 6'b010000, 1, 4'd6, 4'd2);
    step("hold3",       0, 6'b000000, 6'b000000, 0, 3'd0, 4'd0, 0, 6'b001111, 6'b010000, 1, 4'd7, 4'd2);
    step("hold4",       0, 6'b000000, 6'b000000, 0, 3'd0, 4'd0, 0, 6'b001111, 6'b010000, 1, 4'd8, 4'd2);
    step("hold_end",    0, 6'b000000, 6'b000000, 0, 3'd0, 4'd0, 0, 6'b000000, 6'b000000, 0, 4'd9, 4'd2);
    // Zero-length hold is ignored; one-cycle hold stalls only the accept cycle.
    step("hold_n0",     0, 6'b000000, 6'b000000, 1, 3'd3, 4'd0, 0, 6'b000000, 6'b000000, 0, 4'd9, 4'd2);
    step("hold_n0_end", 0, 6'b000000, 6'b000000, 0, 3'd0, 4'd0, 0, 6'b000000, 6'b000000, 0, 4'd9, 4'd2);
    step("hold_n1",     0, 6'b000000, 6'b000000, 1, 3'd1, 4'd1, 0, 6'b000011, 6'b000100, 0, 4'd9, 4'd2);
    step("hold_n1_end", 0, 6'b000000, 6'b000000, 0, 3'd0, 4'd0, 0, 6'b000000, 6'b000000, 0, 4'd10, 4'd2);
    // Hold at ID aborted by a MEM flush.
    step("abort1",      0, 6'b000000, 6'b000000, 1, 3'd2, 4'd5, 0, 6'b000111, 6'b001000, 0, 4'd10, 4'd2);
    step("abort2",      0, 6'b000000, 6'b000000, 0, 3'd0, 4'd0, 0, 6'b000111, 6'b001000, 1, 4'd11, 4'd2);
    step("abort3",      0, 6'b000000, 6'b010000, 0, 3'd0, 4'd0, 0, 6'b000000, 6'b011110, 1, 4'd12, 4'd2);
    step("abort_end",   0, 6'b000000, 6'b000000, 0, 3'd0, 4'd0, 0, 6'b000000, 6'b000000, 0, 4'd12, 4'd3);
    // Hold refused when a flush from above is honoured in the same cycle.
    step("refuse",      0, 6'b000000, 6'b001000, 1, 3'd1, 4'd3, 0, 6'b000000, 6'b001110, 0, 4'd12, 4'd3);
    step("refuse_end",  0, 6'b000000, 6'b000000, 0, 3'd0, 4'd0, 0, 6'b000000, 6'b000000, 0, 4'd12, 4'd4);
    // Reset mid-HOLD (cnt=5) clears everything immediately.
    step("rh1",         0, 6'b000000, 6'b000000, 1, 3'd3, 4'd7, 0, 6'b001111, 6'b010000, 0, 4'd12, 4'd4);
    step("rh2",         0, 6'b000000, 6'b000000, 0, 3'd0, 4'd0, 0, 6'b001111, 6'b010000, 1, 4'd13, 4'd4);
    step("rh_rst",      1, 6'b111111, 6'b111111, 1, 3'd3, 4'd7, 1, 6'b000000, 6'b000000, 0, 4'd0, 4'd0);
    step("rh_rel1",     0, 6'b000000, 6'b000000, 0, 3'd0, 4'd0, 0, 6'b000000, 6'b000000, 0, 4'd0, 4'd0);
    step("rh_rel2",     0, 6'b000000, 6'b000000, 0, 3'd0, 4'd0, 0, 6'b000000, 6'b000000, 0, 4'd0, 4'd0);
    // Saturation of the 4-bit stall counter, then clear.
    step("pre_sat",     0, 6'b000000, 6'b000010, 0, 3'd0, 4'd0, 0, 6'b000000, 6'b000010, 0, 4'd0, 4'd0);
    for (int i = 0; i < 20; i++) begin
      step("sat",       0, 6'b000001, 6'b000000, 0, 3'd0, 4'd0, 0, 6'b000001, 6'b000010, 0,
           (i > 15) ? 4'd15 : 4'(i), 4'd1);
    end
    step("sat_end",     0, 6'b000000, 6'b000000, 0, 3'd0, 4'd0, 0, 6'b000000, 6'b000000, 0, 4'd15, 4'd1);
    step("clr",         0, 6'b000001, 6'b000000, 0, 3'd0, 4'd0, 1, 6'b000001, 6'b000010, 0, 4'd15, 4'd1);
    step("clr_end1",    0, 6'b000000, 6'b000000, 0, 3'd0, 4'd0, 0, 6'b000000, 6'b000000, 0, 4'd0, 4'd0);
    step("clr_end2",    0, 6'b000000, 6'b000000, 0, 3'd0, 4'd0, 0, 6'b000000, 6'b000000, 0, 4'd0, 4'd0);

    repeat (3) @(posedge clk);
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Parametrised pipeline hazard controller for the RISC-V core; successor to the fixed six-stage stall decoder. It merges per-stage stall requests, multi-cycle hold requests from fixed-latency units (multiplier/divider, memory wait) and per-stage redirect/flush requests into one stall vector and one bubble/flush vector. It also keeps saturating stall and flush event counters for performance analysis. It sits beside the pipeline registers, and every stage register consumes one bit of each vector.

## Interface
- `STAGES`, 6: number of stage positions. Bit 0 is the PC, bit 1 is IF, and so on up to WB.
- `HOLD_W`, 4: width of the hold-cycle count.
- `PERF_W`, 16: width of the performance counters.
- `SW`, $clog2(STAGES): stage-index width. This is a derived localparam.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset. Asynchronous, active-high.
- `stallreq` in STAGES: level request. Bit k set means stage k cannot advance this cycle.
- `hold_req` in 1: one-cycle strobe that requests a multi-cycle hold.
- `hold_stage` in SW: index of the stage requesting the hold.
- `hold_cycles` in HOLD_W: total number of hold cycles, N.
- `flushreq` in STAGES: level request. Bit k set means stage k resolved a redirect.
- `perf_clr` in 1: synchronous clear of both counters.
- `stall` out STAGES: bit j set means pipeline register j keeps its value. For j=0, the PC keeps its value.
- `flush` out STAGES: bit j set means the input register of stage j loads a bubble at the next edge. Bit 0 is always 0.
- `hold_busy` out 1: high while the controller is in HOLD.
- `stall_cycles` out PERF_W: count of cycles with stall[0]=1.
- `flush_events` out PERF_W: count of cycles in which a flush request was honoured.

## Operation
- Effective stall level s is the highest k with stallreq[k]=1. While in HOLD, hold_stage_q also counts as a request. With no request, s is none.
- Effective flush level f is the highest k ≥ 1 with flushreq[k]=1. flushreq[0] is ignored.
- Stall only (s defined, and f is none or f ≤ s):
  - stall[j]=1 for 0 ≤ j ≤ s.
  - flush[s+1]=1 if s+1 < STAGES.
  - All other bits are 0.
  - The flush is not honoured. The requester keeps flushreq asserted until it is honoured.
- Flush wins (f defined, and s is none or f > s):
  - flush[j]=1 for 1 ≤ j ≤ f.
  - The stall vector is all zeros, because the stalled instruction is squashed.
  - The PC loads the redirect.
- Hold FSM, IDLE/HOLD:
  - IDLE to HOLD: on hold_req with hold_cycles ≥ 1 and no honoured flush from a stage above hold_stage. The FSM latches hold_stage_q and sets cnt = hold_cycles − 1.
  - The hold stall is already applied in the accept cycle, so the total is exactly N stall cycles.
  - If hold_cycles = 1, the FSM stays in IDLE and only the accept cycle stalls.
  - hold_cycles = 0 is ignored.
  - HOLD: while cnt > 0, cnt decrements each cycle. When cnt = 0, the FSM returns to IDLE at the next edge.
  - HOLD, abort: if a flush with f > hold_stage_q is honoured, the FSM goes to IDLE at the next edge and cnt is cleared.
  - hold_req while in HOLD is ignored; there is no queueing.
- Counters:
  - Counters increment on qualifying cycles and saturate at all-ones.
  - perf_clr takes priority over increment.
- rst high forces stall=0, flush=0, FSM=IDLE, cnt=0, hold_stage_q=0 and both counters=0, whatever the other inputs are.
  - An asserted rst aborts any hold immediately.

## Timing
- stall, flush and hold_busy are combinational from the current inputs and registered state. They have zero-cycle latency.
- Example: hold_req at cycle t with N=3. stall is asserted in cycles t, t+1 and t+2. hold_busy is high in t+1 and t+2 and low in t+3.
- Counter outputs are registered. They reflect cycle t at t+1.
- Reset values of all outputs are 0.
- State changes only on the rising edge of clk, or on async rst.

## Structure
- Shared package holds:
  - stage index constants: PC, IF, ID, EX, MEM, WB.
  - hold FSM state enum: IDLE, HOLD.
  - the RstEnable and Stop level constants used across the core.
- One natural sub-module, `pipe_ctrl_prio`: combinational highest-set-bit encoder with a valid flag. It is instantiated twice, once for s and once for f.
- Everything else is a single always_ff for FSM, hold counter and perf counters, plus a single always_comb for vector generation.

## Test plan
- Reset: assert rst mid-HOLD (cnt=5) → stall=000000 and flush=000000 immediately. After release: hold_busy=0, stall_cycles=0.
- Load-use, stallreq=000100 → stall=000111, flush=001000. stall_cycles increments by 1 per cycle.
- Branch from EX, flushreq=001000 with stallreq=000100 → stall=000000, flush=001110, flush_events increments by 1.
- Stall outranks flush: stallreq=010000 with flushreq=001000 → stall=011111, flush=100000, no flush counted.
- Hold: hold_req, hold_stage=3, hold_cycles=4 → stall=001111 for exactly 4 cycles. hold_busy is high for cycles 2–4, then the FSM returns to IDLE. A second hold_req during HOLD is ignored. With hold_cycles=0, no stall occurs.
- Abort and saturation:
  - During a hold at stage 2, flushreq=010000 → flush=011110 and the FSM returns to IDLE next cycle.
  - With PERF_W=4, 20 continuous stall cycles → stall_cycles=15.
  - perf_clr → stall_cycles=0.
